// File: rtl/rc522_spi_target_if.sv
// SPI pin and register-bus bundle for the RC522 register-access target.
// The slave modport is the target's view; master is the view of whoever drives the SPI pins and serves reads.
interface rc522_spi_target_if #(
    parameter int ADDR_W = 6
);
    logic              sck;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic [ADDR_W-1:0] reg_addr;
    logic              reg_wr;
    logic [7:0]        reg_wdata;
    logic              reg_rd;
    logic [7:0]        reg_rdata;

    modport slave (
        input  sck, cs_n, mosi, reg_rdata,
        output miso, miso_oe, reg_addr, reg_wr, reg_wdata, reg_rd
    );

    modport master (
        output sck, cs_n, mosi, reg_rdata,
        input  miso, miso_oe, reg_addr, reg_wr, reg_wdata, reg_rd
    );
endinterface

// File: rtl/rc522_spi_target.sv
// SPI mode-0 target that emulates RC522 register access: decodes address/data frames
// into single-cycle register strobes and shifts read data back on MISO.
module rc522_spi_target #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              rst,
    rc522_spi_target_if.slave bus,
    output logic              frame_active,
    output logic              err
);
    typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, IGNORE} state_t;

    state_t            state, state_d;
    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic              sck_prev, cs_prev;
    logic              sck_s, cs_s, mosi_s;
    logic              sck_rise, sck_fall, cs_rise, cs_fall;
    logic [2:0]        bit_cnt, bit_cnt_d;
    logic [7:0]        rx_shift, rx_d, tx_shift, tx_d, byte_in;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              wr_q, wr_d, rd_q, rd_d, rd_dly, err_d, active_d;
    logic              in_frame, byte_done;

    // cs_n synchroniser resets low, so a frame already under way at reset never shows a falling edge
    // and is ignored until cs_n has been seen high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            sck_prev  <= sck_s;
            cs_prev   <= cs_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign cs_rise  = cs_s & ~cs_prev;
    assign cs_fall  = ~cs_s & cs_prev;
    assign byte_in  = {rx_shift[6:0], mosi_s};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wr_q         <= 1'b0;
            rd_q         <= 1'b0;
            rd_dly       <= 1'b0;
            err          <= 1'b0;
            frame_active <= 1'b0;
        end else begin
            state        <= state_d;
            bit_cnt      <= bit_cnt_d;
            rx_shift     <= rx_d;
            tx_shift     <= tx_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            rd_dly       <= rd_q;
            err          <= err_d;
            frame_active <= active_d;
        end
    end

    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        rx_d      = rx_shift;
        tx_d      = tx_shift;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        err_d     = 1'b0;
        active_d  = frame_active;
        in_frame  = (state == ADDR) || (state == WDATA) || (state == RDATA);
        byte_done = 1'b0;

        if (rd_dly && state == RDATA)
            tx_d = bus.reg_rdata;

        if (in_frame && sck_rise) begin
            rx_d      = byte_in;
            bit_cnt_d = bit_cnt + 3'd1;
            byte_done = (bit_cnt == 3'd7);
        end

        // The falling edge right after a byte boundary keeps the freshly loaded MSB on MISO.
        if (in_frame && sck_fall && bit_cnt != 3'd0)
            tx_d = {tx_shift[6:0], 1'b0};

        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = ADDR;
                    bit_cnt_d = '0;
                    rx_d      = '0;
                    tx_d      = 8'h00;
                    active_d  = 1'b1;
                end
            end
            ADDR: begin
                if (byte_done) begin
                    if (byte_in[0]) begin
                        err_d   = 1'b1;
                        tx_d    = 8'h00;
                        state_d = IGNORE;
                    end else begin
                        addr_d = byte_in[ADDR_W:1];
                        if (byte_in[7]) begin
                            rd_d    = 1'b1;
                            state_d = RDATA;
                        end else begin
                            state_d = WDATA;
                        end
                    end
                end
            end
            WDATA: begin
                if (byte_done) begin
                    wr_d    = 1'b1;
                    wdata_d = byte_in;
                end
            end
            RDATA: begin
                if (byte_done) begin
                    if (byte_in[7]) begin
                        addr_d = byte_in[ADDR_W:1];
                        rd_d   = 1'b1;
                    end else begin
                        tx_d = 8'h00;
                    end
                end
            end
            IGNORE: begin
                tx_d = 8'h00;
            end
            default: state_d = IDLE;
        endcase

        // A completed byte is still strobed above; only a partial byte is flagged and dropped.
        if (cs_rise) begin
            if (bit_cnt_d != 3'd0)
                err_d = 1'b1;
            state_d   = IDLE;
            bit_cnt_d = '0;
            tx_d      = 8'h00;
            active_d  = 1'b0;
        end
    end

    assign bus.miso      = tx_shift[7];
    assign bus.miso_oe   = frame_active;
    assign bus.reg_addr  = addr_q;
    assign bus.reg_wr    = wr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_rd    = rd_q;
endmodule

// File: tb/tb_rc522_spi_target.sv
// Directed bench for rc522_spi_target: table of SPI frames with expected strobes/MISO bytes,
// plus hand-written abort and mid-frame reset sequences.
module tb_rc522_spi_target;
    localparam int HALF = 8;

    typedef struct {
        string            name;
        int               nbytes;
        logic [0:2][7:0]  mosi;
        logic [0:2][7:0]  miso;
        int               nstrobe;
        logic [0:2][14:0] strobe;
        int               nerr;
        logic [5:0]       ma;
        logic [7:0]       mv;
        logic [5:0]       mb;
        logic [7:0]       mvb;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_active, err;
    logic [7:0] mem [64];

    logic [14:0] strobe_q [$];
    int          err_count;
    int          overlap_count = 0;
    int          check_count = 0;
    int          pass_count = 0;

    rc522_spi_target_if #(.ADDR_W(6)) bus ();

    rc522_spi_target #(.SYNC_STAGES(2), .ADDR_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .frame_active (frame_active),
        .err          (err)
    );

    always #5 clk = ~clk;

    assign bus.reg_rdata = mem[bus.reg_addr];

    // Strobe/err log, sampled on the falling clock edge
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.reg_wr) strobe_q.push_back({1'b0, bus.reg_addr, bus.reg_wdata});
            if (bus.reg_rd) strobe_q.push_back({1'b1, bus.reg_addr, 8'h00});
            if (bus.reg_wr && bus.reg_rd) overlap_count++;
            if (err) err_count++;
        end
    end

    function automatic logic [14:0] wr_ev(input logic [5:0] a, input logic [7:0] d);
        return {1'b0, a, d};
    endfunction

    function automatic logic [14:0] rd_ev(input logic [5:0] a);
        return {1'b1, a, 8'h00};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic sendBits(input logic [7:0] b, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            bus.mosi = b[i];
            repeat (HALF) @(negedge clk);
            rx[i] = bus.miso;
            bus.sck = 1'b1;
            repeat (HALF) @(negedge clk);
            bus.sck = 1'b0;
        end
    endtask

    task automatic applyStimulus(input int nbytes, input logic [0:2][7:0] mosi, output logic [0:2][7:0] miso);
        logic [7:0] b;
        miso = '0;
        strobe_q.delete();
        err_count = 0;
        bus.cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int k = 0; k < nbytes; k++) begin
            sendBits(mosi[k], 8, b);
            miso[k] = b;
        end
        repeat (HALF) @(negedge clk);
        bus.cs_n = 1'b1;
        repeat (4 * HALF) @(negedge clk);
    endtask

    initial begin
        vec_t            vecs [8];
        logic [0:2][7:0] got;
        logic [7:0]      b;

        vecs[0] = '{"single_write", 2, {8'h02, 8'h0F, 8'h00}, {8'h00, 8'h00, 8'h00},
                    1, {wr_ev(6'h01, 8'h0F), 15'h0, 15'h0}, 0, 6'h00, 8'h00, 6'h00, 8'h00};
        vecs[1] = '{"single_read", 2, {8'h88, 8'h00, 8'h00}, {8'h00, 8'hA5, 8'h00},
                    1, {rd_ev(6'h04), 15'h0, 15'h0}, 0, 6'h04, 8'hA5, 6'h05, 8'h00};
        vecs[2] = '{"burst_read", 3, {8'h88, 8'h8A, 8'h00}, {8'h00, 8'h11, 8'h22},
                    2, {rd_ev(6'h04), rd_ev(6'h05), 15'h0}, 0, 6'h04, 8'h11, 6'h05, 8'h22};
        vecs[3] = '{"burst_write", 3, {8'h12, 8'hAA, 8'hBB}, {8'h00, 8'h00, 8'h00},
                    2, {wr_ev(6'h09, 8'hAA), wr_ev(6'h09, 8'hBB), 15'h0}, 0, 6'h00, 8'h00, 6'h00, 8'h00};
        vecs[4] = '{"bad_addr", 2, {8'h03, 8'h55, 8'h00}, {8'h00, 8'h00, 8'h00},
                    0, {15'h0, 15'h0, 15'h0}, 1, 6'h01, 8'hC3, 6'h00, 8'h00};
        vecs[5] = '{"write_top_addr", 2, {8'h7E, 8'h5A, 8'h00}, {8'h00, 8'h00, 8'h00},
                    1, {wr_ev(6'h3F, 8'h5A), 15'h0, 15'h0}, 0, 6'h00, 8'h00, 6'h00, 8'h00};
        vecs[6] = '{"read_top_addr", 2, {8'hFE, 8'h00, 8'h00}, {8'h00, 8'h5C, 8'h00},
                    1, {rd_ev(6'h3F), 15'h0, 15'h0}, 0, 6'h3F, 8'h5C, 6'h00, 8'h00};
        vecs[7] = '{"read_no_term", 1, {8'h80, 8'h00, 8'h00}, {8'h00, 8'h00, 8'h00},
                    1, {rd_ev(6'h00), 15'h0, 15'h0}, 0, 6'h00, 8'h77, 6'h01, 8'h00};

        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        rst      = 1'b1;
        bus.sck  = 1'b0;
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        err_count = 0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_outputs",
                    {bus.miso, bus.miso_oe, bus.reg_wr, bus.reg_rd, bus.reg_addr, bus.reg_wdata, frame_active, err},
                    32'h0);
        repeat (4 * HALF) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            mem[vecs[v].ma] = vecs[v].mv;
            mem[vecs[v].mb] = vecs[v].mvb;
            applyStimulus(vecs[v].nbytes, vecs[v].mosi, got);
            for (int k = 0; k < vecs[v].nbytes; k++)
                checkOutput($sformatf("%s miso[%0d]", vecs[v].name, k), got[k], vecs[v].miso[k]);
            checkOutput($sformatf("%s strobe_count", vecs[v].name), strobe_q.size(), vecs[v].nstrobe);
            for (int k = 0; k < vecs[v].nstrobe && k < strobe_q.size(); k++)
                checkOutput($sformatf("%s strobe[%0d]", vecs[v].name, k), strobe_q[k], vecs[v].strobe[k]);
            checkOutput($sformatf("%s err_count", vecs[v].name), err_count, vecs[v].nerr);
        end

        // Abort: partial second byte must be dropped with a single err pulse
        strobe_q.delete();
        err_count = 0;
        bus.cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        sendBits(8'h02, 8, b);
        sendBits(8'hFF, 5, b);
        repeat (HALF) @(negedge clk);
        bus.cs_n = 1'b1;
        repeat (4 * HALF) @(negedge clk);
        checkOutput("abort strobe_count", strobe_q.size(), 0);
        checkOutput("abort err_count", err_count, 1);
        applyStimulus(2, {8'h04, 8'h33, 8'h00}, got);
        checkOutput("after_abort strobe_count", strobe_q.size(), 1);
        if (strobe_q.size() > 0) checkOutput("after_abort strobe[0]", strobe_q[0], wr_ev(6'h02, 8'h33));
        checkOutput("after_abort err_count", err_count, 0);

        // Reset in the middle of a frame; rest of that frame must be ignored
        strobe_q.delete();
        err_count = 0;
        bus.cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        sendBits(8'h02, 8, b);
        sendBits(8'h0F, 3, b);
        checkOutput("pre_reset frame_active", frame_active, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("mid_reset outputs",
                    {bus.miso, bus.miso_oe, bus.reg_wr, bus.reg_rd, bus.reg_addr, bus.reg_wdata, frame_active, err},
                    32'h0);
        rst = 1'b0;
        sendBits(8'h0F, 5, b);
        sendBits(8'h0F, 8, b);
        checkOutput("post_reset active_oe", {frame_active, bus.miso_oe}, 2'b00);
        repeat (HALF) @(negedge clk);
        bus.cs_n = 1'b1;
        repeat (4 * HALF) @(negedge clk);
        checkOutput("post_reset strobe_count", strobe_q.size(), 0);
        checkOutput("post_reset err_count", err_count, 0);
        applyStimulus(2, {8'h02, 8'h0F, 8'h00}, got);
        checkOutput("recover strobe_count", strobe_q.size(), 1);
        if (strobe_q.size() > 0) checkOutput("recover strobe[0]", strobe_q[0], wr_ev(6'h01, 8'h0F));

        checkOutput("no_wr_rd_overlap", overlap_count, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule

// File: doc/rc522_spi_target.md
Name: rc522_spi_target

Overview:
- SPI mode-0 target (slave) that emulates the RC522 register-access protocol in our own logic.
- Sits behind the SPI pins, so an SPI master can drive it in simulation in place of a real RC522 chip.
- Decodes address/data frames and issues single-cycle strobes on a simple register bus.
- Shifts register read data back on MISO.
- SPI inputs are asynchronous to clk. They are synchronised and edge-detected internally, and all logic runs on clk.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the synchronisers on sck, cs_n and mosi (minimum 2).
- ADDR_W, 6, register address width, taken from address byte bits [6:1].

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sck  in  1  SPI clock from master (idle low)
- cs_n  in  1  SPI chip select, active low
- mosi  in  1  master-out data, MSB first
- miso  out  1  target-out data, MSB first
- miso_oe  out  1  MISO drive enable; high only while the synchronised cs_n is low
- reg_addr  out  ADDR_W  register address for the current strobe
- reg_wr  out  1  one-cycle write strobe
- reg_wdata  out  8  write data, valid with reg_wr
- reg_rd  out  1  one-cycle read strobe
- reg_rdata  in  8  read data; must be valid in the cycle after reg_rd
- frame_active  out  1  high from the synchronised cs_n fall to its rise
- err  out  1  one-cycle protocol-error pulse

Behaviour:
- Reset: all outputs 0, shift registers 0, bit counter 0, state IDLE. Reset mid-frame aborts the frame; the block then ignores the bus until a cs_n high is seen.
- Clock ratio: sck high and low phases must each be at least SYNC_STAGES+2 clk cycles.
- Sampling: on each synchronised sck rising edge, shift mosi into rx_shift and increment the 3-bit bit counter.
- Driving: on each synchronised sck falling edge, shift tx_shift left; miso = tx_shift[7].
- Byte complete: the 8th rising edge, with the counter wrapping to 0.
- Address byte format: bit7 = 1 means read, 0 means write; bits[6:1] = address; bit0 must be 0.
- States:
  - IDLE: wait for the cs_n falling edge, then go to ADDR. Clear counter; tx_shift = 0x00, so MISO sends 0x00 during the first byte.
  - ADDR: on byte complete:
    - If bit0 = 1: pulse err, go to IGNORE.
    - Else latch the address. Bit7 = 0 goes to WDATA. Bit7 = 1 pulses reg_rd next cycle, then goes to RDATA.
  - WDATA: each completed byte pulses reg_wr for one cycle with the latched reg_addr and reg_wdata = byte. The address does not increment, so a burst writes repeatedly to the same address.
  - RDATA:
    - reg_rdata is captured into tx_shift one cycle after reg_rd and transmitted in the next byte.
    - Each completed MOSI byte with bit7 = 1 latches a new address and pulses reg_rd.
    - A byte with bit7 = 0 (terminator, normally 0x00) issues no read; tx_shift is loaded with 0x00.
  - IGNORE: hold miso low and wait for cs_n to rise.
- cs_n rise in any state: return to IDLE and clear the counter. If the counter is non-zero (partial byte), pulse err and discard the byte with no strobe.
- Simultaneous events:
  - A cs_n rise in the same cycle as byte complete: the byte is processed (strobe issued) before returning to IDLE.
  - reg_wr and reg_rd are never high in the same cycle.
- Latency: strobe asserts 1 cycle after the synchronised 8th rising edge is detected.

Test Plan:
- Single write: cs low, MOSI 0x02, 0x0F, cs high -> exactly one reg_wr with reg_addr=0x01, reg_wdata=0x0F; no reg_rd; err=0.
- Single read with reg_rdata=0xA5 for addr 0x04: MOSI 0x88, 0x00 -> one reg_rd with reg_addr=0x04; MISO bytes 0x00, 0xA5.
- Burst read with addr 0x04 -> 0x11 and addr 0x05 -> 0x22: MOSI 0x88, 0x8A, 0x00 -> two reg_rd pulses (0x04, 0x05); MISO 0x00, 0x11, 0x22.
- Burst write: MOSI 0x12, 0xAA, 0xBB -> two reg_wr pulses to addr 0x09 with data 0xAA then 0xBB.
- Abort: MOSI 0x02 then 5 bits of the next byte, cs high -> no reg_wr; one err pulse; the next frame 0x04, 0x33 writes addr 0x02 with 0x33 correctly.
- Bad address 0x03 then 0x55 -> err pulse after the first byte, no strobes; rst asserted mid-frame -> all outputs 0 and the frame is ignored until cs high.
